// File: rtl/tile_occupancy_accumulator.sv
// Per-tile point histogram over a 16x16 grid; lanes of each beat are counted serially and the
// histogram is streamed out (read-and-clear) on frame end. Optional peak tracker: TILE_OCC_PEAK_EN.
module tile_occupancy_accumulator #(
   parameter int COUNT_W = 8,
   parameter int LANES   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        tile_indices,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               frame_end,
   output logic [7:0]         out_tile,
   output logic [COUNT_W-1:0] out_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy
`ifdef TILE_OCC_PEAK_EN
   ,
   output logic [7:0]         peak_tile,
   output logic [COUNT_W-1:0] peak_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROC = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
   localparam logic [1:0]         LANE_LAST = 2'(LANES - 1);

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + COUNT_W'(1);
      end
   endfunction

   state_t             state_r;
   logic [COUNT_W-1:0] count_mem_r [0:255];
   logic [31:0]        beat_r;
   logic [1:0]         lane_r;
   logic [7:0]         addr_r;
   logic               frame_pending_r;
   logic               in_ready_r;
   logic               busy_r;
   logic               out_valid_r;
   logic               out_last_r;
   logic [7:0]         out_tile_r;
   logic [COUNT_W-1:0] out_count_r;
`ifdef TILE_OCC_PEAK_EN
   logic [7:0]         peak_tile_r;
   logic [COUNT_W-1:0] peak_count_r;
`endif

   logic [7:0]         lane_tile_s;
   logic [COUNT_W-1:0] lane_inc_s;
   logic [7:0]         next_addr_s;
   logic               pending_eff_s;

   assign lane_tile_s   = beat_r[{lane_r, 3'b000} +: 8];
   assign lane_inc_s    = sat_inc(count_mem_r[lane_tile_s]);
   assign next_addr_s   = addr_r + 8'd1;
   // A frame_end arriving on the final lane still sends us straight into the dump.
   assign pending_eff_s = frame_pending_r | frame_end;

   // Control FSM, counter array and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         for (int i = 0; i < 256; i++) begin
            count_mem_r[i] <= {COUNT_W{1'b0}};
         end
         beat_r          <= 32'h0000_0000;
         lane_r          <= 2'd0;
         addr_r          <= 8'd0;
         frame_pending_r <= 1'b0;
         in_ready_r      <= 1'b1;
         busy_r          <= 1'b0;
         out_valid_r     <= 1'b0;
         out_last_r      <= 1'b0;
         out_tile_r      <= 8'd0;
         out_count_r     <= {COUNT_W{1'b0}};
`ifdef TILE_OCC_PEAK_EN
         peak_tile_r     <= 8'd0;
         peak_count_r    <= {COUNT_W{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  beat_r          <= tile_indices;
                  lane_r          <= 2'd0;
                  state_r         <= ST_PROC;
                  frame_pending_r <= frame_end;
                  in_ready_r      <= 1'b0;
                  busy_r          <= 1'b1;
               end else if (frame_pending_r) begin
                  state_r     <= ST_DUMP;
                  addr_r      <= 8'd0;
                  out_valid_r <= 1'b1;
                  out_tile_r  <= 8'd0;
                  out_count_r <= count_mem_r[8'h00];
                  out_last_r  <= 1'b0;
                  in_ready_r  <= 1'b0;
                  busy_r      <= 1'b1;
               end else begin
                  frame_pending_r <= frame_end;
                  in_ready_r      <= ~frame_end;
               end
            end
            ST_PROC: begin
               count_mem_r[lane_tile_s] <= lane_inc_s;
               if (frame_end) begin
                  frame_pending_r <= 1'b1;
               end
`ifdef TILE_OCC_PEAK_EN
               if (lane_inc_s > peak_count_r) begin
                  peak_tile_r  <= lane_tile_s;
                  peak_count_r <= lane_inc_s;
               end
`endif
               if (lane_r == LANE_LAST) begin
                  if (pending_eff_s) begin
                     state_r     <= ST_DUMP;
                     addr_r      <= 8'd0;
                     out_valid_r <= 1'b1;
                     out_tile_r  <= 8'd0;
                     // Tile 0 may be written by this very lane; forward the new value.
                     out_count_r <= (lane_tile_s == 8'h00) ? lane_inc_s : count_mem_r[8'h00];
                     out_last_r  <= 1'b0;
                  end else begin
                     state_r    <= ST_IDLE;
                     in_ready_r <= 1'b1;
                     busy_r     <= 1'b0;
                  end
               end else begin
                  lane_r <= lane_r + 2'd1;
               end
            end
            ST_DUMP: begin
               if (out_ready) begin
                  count_mem_r[addr_r] <= {COUNT_W{1'b0}};
                  if (out_last_r) begin
                     state_r         <= ST_IDLE;
                     addr_r          <= 8'd0;
                     frame_pending_r <= 1'b0;
                     out_valid_r     <= 1'b0;
                     out_last_r      <= 1'b0;
                     out_tile_r      <= 8'd0;
                     out_count_r     <= {COUNT_W{1'b0}};
                     in_ready_r      <= 1'b1;
                     busy_r          <= 1'b0;
`ifdef TILE_OCC_PEAK_EN
                     peak_tile_r     <= 8'd0;
                     peak_count_r    <= {COUNT_W{1'b0}};
`endif
                  end else begin
                     addr_r      <= next_addr_s;
                     out_tile_r  <= next_addr_s;
                     out_count_r <= count_mem_r[next_addr_s];
                     out_last_r  <= (next_addr_s == 8'hFF);
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
               in_ready_r  <= ~frame_pending_r;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_tile  = out_tile_r;
   assign out_count = out_count_r;
`ifdef TILE_OCC_PEAK_EN
   assign peak_tile  = peak_tile_r;
   assign peak_count = peak_count_r;
`endif

endmodule

// File: tb/tb_tile_occupancy_accumulator.sv
// Self-checking bench for tile_occupancy_accumulator: directed scenarios with random beats and
// random out_ready, checked against a per-tile count array model.
module tb_tile_occupancy_accumulator;

   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   tile_indices = 32'h0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          frame_end = 1'b0;
   logic [7:0]    out_tile;
   logic [CW-1:0] out_count;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;
`ifdef TILE_OCC_PEAK_EN
   logic [7:0]    peak_tile;
   logic [CW-1:0] peak_count;
`endif

   int total = 0;
   int bad   = 0;
   int model [256];
   int pk_tile = 0;
   int pk_cnt  = 0;

   tile_occupancy_accumulator #(.COUNT_W(CW), .LANES(4)) dut (
      .clk(clk), .reset(reset), .tile_indices(tile_indices), .in_valid(in_valid),
      .in_ready(in_ready), .frame_end(frame_end), .out_tile(out_tile), .out_count(out_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
`ifdef TILE_OCC_PEAK_EN
      , .peak_tile(peak_tile), .peak_count(peak_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int t = 0; t < 256; t++) model[t] = 0;
      pk_tile = 0;
      pk_cnt  = 0;
   endtask

   // Each lane is one point landing on tile {Y,X}; counts stop at the maximum.
   task automatic count_beat(input logic [31:0] b);
      int t;
      for (int l = 0; l < 4; l++) begin
         t = int'(b[l*8 +: 8]);
         if (model[t] < MAXC) model[t] = model[t] + 1;
         if (model[t] > pk_cnt) begin
            pk_cnt  = model[t];
            pk_tile = t;
         end
      end
   endtask

   task automatic send_beat(input logic [31:0] b, input bit fe, input bit chk_gap);
      int n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      check("accept_wait", 32'(n < 40), 32'd1);
      tile_indices = b;
      in_valid     = 1'b1;
      frame_end    = fe;
      tick();
      in_valid  = 1'b0;
      frame_end = 1'b0;
      count_beat(b);
      if (chk_gap) begin
         n = 0;
         while (!in_ready && n < 10) begin
            n++;
            tick();
         end
         check("in_ready_gap", 32'(n), 32'd4);
      end
   endtask

   task automatic pulse_frame_end();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic dump(input bit rnd, input int stop_at, input bit fe_mid);
      int  e = 0;
      int  cyc = 0;
      int  n = 0;
      bit  r;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("dump_start", 32'(out_valid), 32'd1);
`ifdef TILE_OCC_PEAK_EN
      check("peak_tile", 32'(peak_tile), 32'(pk_tile));
      check("peak_count", 32'(peak_count), 32'(pk_cnt));
`endif
      while (e < stop_at && cyc < 3000) begin
         check("dump_tile", 32'(out_tile), 32'(e));
         check("dump_count", 32'(out_count), 32'(model[e]));
         check("dump_last", 32'(out_last), 32'(e == 255));
         check("dump_flags", 32'({out_valid, busy, in_ready}), 32'b110);
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = r;
         frame_end = fe_mid && (e == 50);
         tick();
         cyc++;
         if (r) begin
            model[e] = 0;
            e++;
         end
      end
      out_ready = 1'b0;
      frame_end = 1'b0;
      check("dump_words", 32'(e), 32'(stop_at));
      if (stop_at == 256) begin
         pk_tile = 0;
         pk_cnt  = 0;
         check("dump_end_flags", 32'({out_valid, busy, in_ready, out_last}), 32'b0010);
`ifdef TILE_OCC_PEAK_EN
         check("peak_clear", 32'({peak_tile, peak_count}), 32'd0);
`endif
         repeat (3) tick();
         check("no_redump", 32'({out_valid, busy}), 32'd0);
      end
   endtask

   initial begin
      int n;
      clear_model();
      // Reset held for two cycles.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_outputs", 32'({out_last, out_tile, out_count}), 32'd0);
      pulse_frame_end();
      dump(1'b0, 256, 1'b0);

      // Known beat: 0x33, 0x11, 0x11, 0x00.
      send_beat(32'h0011_1133, 1'b0, 1'b1);
`ifdef TILE_OCC_PEAK_EN
      check("peak_tile_11", 32'(peak_tile), 32'h11);
      check("peak_count_2", 32'(peak_count), 32'd2);
`endif
      check("model_11", 32'(model[8'h11]), 32'd2);
      pulse_frame_end();
      dump(1'b0, 256, 1'b0);
      pulse_frame_end();
      dump(1'b0, 256, 1'b0);

      // Saturation: 256 increments of tile 0x05.
      for (int i = 0; i < 64; i++) send_beat(32'h0505_0505, 1'b0, 1'b1);
      check("model_sat", 32'(model[5]), 32'(MAXC));
      pulse_frame_end();
      dump(1'b1, 256, 1'b0);

      // Random beats, then frame_end coincident with an accepted beat.
      for (int i = 0; i < 6; i++) send_beat($urandom, 1'b0, 1'b1);
      send_beat($urandom, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         n++;
         tick();
      end
      check("dump_after_lane3_a", 32'(n), 32'd4);
      dump(1'b1, 256, 1'b1);

      // frame_end while lane 1 is being counted.
      for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'b1);
      send_beat($urandom, 1'b0, 1'b0);
      tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         n++;
         tick();
      end
      check("dump_after_lane3_b", 32'(n), 32'd2);
      dump(1'b1, 256, 1'b0);

      // Reset in the middle of a dump aborts it and clears every counter.
      for (int i = 0; i < 8; i++) send_beat($urandom & 32'h0F0F_0F0F, 1'b0, 1'b1);
      pulse_frame_end();
      dump(1'b0, 100, 1'b0);
      reset = 1'b1;
      tick();
      check("midreset_flags", 32'({out_valid, busy, in_ready}), 32'b001);
      reset = 1'b0;
      clear_model();
      tick();
      check("midreset_idle", 32'({out_valid, busy, in_ready}), 32'b001);
      pulse_frame_end();
      dump(1'b1, 256, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
